// File: rtl/serial_adder_pkg.sv
// Shared types for the digit-serial adder: FSM state encoding and counter sizing.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One spare bit so the counter can reach N without wrapping.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Single-bit full adder cell, chained DIGIT times inside serial_adder.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Digit-serial adder: WIDTH-bit a + b + cin, DIGIT bits per clock, LSB first.
// Handshake: a request is taken on any rising edge where start=1 and ready=1; done pulses one cycle with the result.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_adder: WIDTH must be >= 2 and an integer multiple of DIGIT");
  end

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] s;
  logic [WIDTH-1:0] res_shift;
  logic             last;

  assign c[0] = carry_q;

  for (genvar i = 0; i < DIGIT; i++) begin : g_ripple
    fa_cell u_fa (
      .a   (a_q[i]),
      .b   (b_q[i]),
      .cin (c[i]),
      .sum (s[i]),
      .cout(c[i+1])
    );
  end

  // New digit enters from the top so the LSB digit ends up at bit 0 after N shifts.
  if (N == 1) begin : g_single
    assign res_shift = s;
  end else begin : g_multi
    assign res_shift = {s, res_q[WIDTH-1:DIGIT]};
  end

  assign last = (cnt_q == CW'(N - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        res_d   = res_shift;
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        carry_d = c[DIGIT];
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          // c[DIGIT-1] is the carry entering bit WIDTH-1 within the final digit.
          sum_d   = res_shift;
          cout_d  = c[DIGIT];
          ovf_d   = c[DIGIT] ^ c[DIGIT-1];
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready     = (state_q != RUN);
  assign done      = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule
